mem_xfer_ctrl: RTL and testbench

MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

---
 rtl/mem_xfer_pkg.sv | 20 ++
 rtl/xfer_idx_cnt.sv | 43 ++++
 rtl/mem_xfer_ctrl.sv | 118 +++++++++++
 tb/tb_mem_xfer_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_xfer_pkg : shared defaults and FSM state encoding            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_xfer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } xfer_state_e;

endpackage : mem_xfer_pkg
`default_nettype wire

// File: rtl/xfer_idx_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xfer_idx_cnt : word index counter with latched length and        |
// |                terminal-count compare                            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module xfer_idx_cnt
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   w_idx_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            len_q <= '0;
        end else if (load_i) begin
            idx_q <= '0;
            len_q <= len_i;
        end else if (inc_i) begin
            idx_q <= idx_q + ADDR_W'(1);
        end
    end

    // Compare one bit wider so a full-depth length terminates without wrapping idx.
    assign w_idx_p1 = {1'b0, idx_q} + (ADDR_W+1)'(1);
    assign last_o   = (w_idx_p1 == len_q);
    assign idx_o    = idx_q;

endmodule : xfer_idx_cnt
`default_nettype wire

// File: rtl/mem_xfer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_xfer_ctrl : reads A[i],B[i], feeds external adder, writes    |
// |                 C[i] = A[i]+B[i]; three cycles per word          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rdA_data,
    input  logic [DATA_W-1:0] rdB_data,
    output logic [DATA_W-1:0] DOut1,
    output logic [DATA_W-1:0] DOut2,
    input  logic [DATA_W-1:0] ADDOut,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    xfer_state_e       state_q, state_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;
    logic              cnt_load, cnt_inc, cnt_last;
    logic [ADDR_W-1:0] idx;

    xfer_idx_cnt #(
        .ADDR_W (ADDR_W)
    ) u_idx_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .len_i  (len),
        .inc_i  (cnt_inc),
        .idx_o  (idx),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout1_q <= '0;
            dout2_q <= '0;
        end else begin
            state_q <= state_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dout1_d  = dout1_q;
        dout2_d  = dout2_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        cnt_load = 1'b1;
                        state_d  = ST_READ;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                rd_en   = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // Memory data is valid in the cycle after rd_en.
                dout1_d = rdA_data;
                dout2_d = rdB_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_addr = idx;
    assign wr_addr = idx;
    assign wr_data = ADDOut;
    assign DOut1   = dout1_q;
    assign DOut2   = dout2_q;

endmodule : mem_xfer_ctrl
`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_xfer_ctrl : vector table, random transfers and reset      |
// |                    abort against a word-level reference model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_xfer_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rdA_data = '0;
    logic [DW-1:0] rdB_data = '0;
    logic [DW-1:0] DOut1, DOut2;
    logic [DW-1:0] ADDOut;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done;

    logic [DW-1:0] memA [DEPTH];
    logic [DW-1:0] memB [DEPTH];
    int            wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    int            rd_cnt = 0;
    int            busy_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_xfer_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rdA_data (rdA_data),
        .rdB_data (rdB_data),
        .DOut1    (DOut1),
        .DOut2    (DOut2),
        .ADDOut   (ADDOut),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    // External adder beside the controller.
    assign ADDOut = DOut1 + DOut2;

    always #5 clk = ~clk;

    // Source memories with one-cycle read latency; destination write log.
    always @(posedge clk) begin
        if (rd_en) begin
            rdA_data <= memA[rd_addr];
            rdB_data <= memB[rd_addr];
            rd_cnt   <= rd_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (wr_en) begin
            wlog_a.push_back(int'(wr_addr));
            wlog_d.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [127:0] a, input logic [127:0] b);
        for (int i = 0; i < DEPTH; i++) begin
            memA[i] = a[i*8 +: 8];
            memB[i] = b[i*8 +: 8];
        end
    endtask

    // One transfer of n words; expc holds the expected C[i] bytes.
    task automatic run_check(input int n, input logic [127:0] expc, input bit glitch);
        int w0, r0, b0, off;
        logic [DW-1:0] d1_prev, d2_prev;
        w0 = wlog_a.size();
        @(negedge clk);
        r0 = rd_cnt;
        b0 = busy_cnt;
        d1_prev = DOut1;
        d2_prev = DOut2;
        start = 1'b1;
        len = (AW+1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        len = (AW+1)'($urandom);
        off = 0;
        while (!done && off < 100) begin
            start = (glitch && off == 1);
            @(posedge clk);
            #1;
            off++;
        end
        start = 1'b0;
        chk("done_latency", off, 3*n);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("busy_after_done", {31'b0, busy}, 0);
        chk("write_count", wlog_a.size() - w0, n);
        chk("read_count", rd_cnt - r0, n);
        chk("busy_cycles", busy_cnt - b0, 3*n + 1);
        for (int i = 0; i < n; i++) begin
            if (w0 + i < wlog_a.size()) begin
                chk("write_addr", wlog_a[w0+i], i);
                chk("write_data", {24'b0, wlog_d[w0+i]}, {24'b0, expc[i*8 +: 8]});
            end
        end
        @(posedge clk);
        #1;
        chk("dout1_hold", {24'b0, DOut1}, {24'b0, (n > 0) ? memA[n-1] : d1_prev});
        chk("dout2_hold", {24'b0, DOut2}, {24'b0, (n > 0) ? memB[n-1] : d2_prev});
    endtask

    typedef struct {
        int           n;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [127:0] ra, rb, rc;
        int n, w0;

        tbl[0] = '{1, 128'h08, 128'h03, 128'h0B};
        tbl[1] = '{3, 128'h811B0B, 128'h83531C, 128'h046E27};
        tbl[2] = '{0, 128'h0, 128'h0, 128'h0};
        tbl[3] = '{2, 128'h5BDB, 128'hE3D3, 128'h3EAE};
        tbl[4].n = 16;
        for (int i = 0; i < DEPTH; i++) begin
            tbl[4].a[i*8 +: 8] = 8'(i);
            tbl[4].b[i*8 +: 8] = 8'hF0;
            tbl[4].c[i*8 +: 8] = 8'(8'hF0 + i);
        end

        load_mem('0, '0);
        #1;
        chk("rst_rd_en", {31'b0, rd_en}, 0);
        chk("rst_wr_en", {31'b0, wr_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_dout1", {24'b0, DOut1}, 0);
        chk("rst_dout2", {24'b0, DOut2}, 0);
        chk("rst_rd_addr", {28'b0, rd_addr}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load_mem(tbl[v].a, tbl[v].b);
            run_check(tbl[v].n, tbl[v].c, v == 1);
        end

        // Random transfers against the word-level model C[i] = (A[i]+B[i]) mod 256.
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                ra[i*8 +: 8] = 8'($urandom);
                rb[i*8 +: 8] = 8'($urandom);
                rc[i*8 +: 8] = 8'(ra[i*8 +: 8] + rb[i*8 +: 8]);
            end
            load_mem(ra, rb);
            run_check(n, rc, t[0]);
        end

        // Reset in the middle of a len=4 transfer, right after the second write.
        for (int i = 0; i < DEPTH; i++) begin
            ra[i*8 +: 8] = 8'($urandom);
            rb[i*8 +: 8] = 8'($urandom);
            rc[i*8 +: 8] = 8'(ra[i*8 +: 8] + rb[i*8 +: 8]);
        end
        load_mem(ra, rb);
        w0 = wlog_a.size();
        @(negedge clk);
        start = 1'b1;
        len = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rd_en", {31'b0, rd_en}, 0);
        chk("abort_wr_en", {31'b0, wr_en}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_dout1", {24'b0, DOut1}, 0);
        chk("abort_dout2", {24'b0, DOut2}, 0);
        chk("abort_wr_data", {24'b0, wr_data}, 0);
        chk("abort_addr", {28'b0, wr_addr}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", wlog_a.size() - w0, 2);
        for (int i = 0; i < 2; i++) begin
            if (w0 + i < wlog_a.size()) begin
                chk("abort_waddr", wlog_a[w0+i], i);
                chk("abort_wdata", {24'b0, wlog_d[w0+i]}, {24'b0, rc[i*8 +: 8]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_check(4, rc, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_xfer_ctrl
`default_nettype wire
